spi_memory_burst: RTL and testbench
===================================

SPI_MEMORY_BURST -- requirements
Module: spi_memory_burst

Interface
REQ-001 Parameter ADDR_WIDTH, default 7: address bits; depth SHALL be 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 8: word width in bits.
REQ-003 Parameter SYNC_STAGES, default 2 (min 2): synchroniser flops per SPI input.
REQ-004 Parameter CPHA, default 0: 0 = sample on sclk rising / launch on falling; 1 = sample on falling / launch on rising.
REQ-005 clk  input  1  FPGA clock; one clock domain, all state on clk rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 sclk_pin  input  1  SPI clock, asynchronous to clk.
REQ-008 cs_pin  input  1  SPI chip select, active low.
REQ-009 mosi_pin  input  1  SPI master out, slave in.
REQ-010 miso_pin  output  1  SPI master in, slave out; registered.
REQ-011 miso_en  output  1  high when miso_pin is to be driven onto the bus (tristate enable for the top level).
REQ-012 leds  output  4  debug: {state[1:0], cs_sync, miso_en}.

Function
REQ-013 sclk, cs and mosi SHALL each pass through SYNC_STAGES flops; sclk rising/falling edges SHALL be single-clk pulses from the last two sync stages.
REQ-014 Timing assumption: sclk high and low times each >= SYNC_STAGES+3 clk periods; slower is always legal.
REQ-015 States SHALL be IDLE, CMD, READ, WRITE (encodings 00, 01, 10, 11).
REQ-016 IDLE -> CMD on the clk where cs_sync is low; bit_cnt cleared.
REQ-017 CMD SHALL shift in ADDR_WIDTH address bits MSB-first, then 1 R/W bit (1 = read), one bit per sample edge.
REQ-018 On the sample edge of the R/W bit: address register loaded; state -> READ if R/W=1, else -> WRITE; bit_cnt cleared.
REQ-019 READ: on a launch edge with bit_cnt==0, the shift register SHALL load mem[addr] and addr SHALL increment; on other launch edges it SHALL shift left; miso_pin = shift-register MSB.
REQ-020 READ: bit_cnt SHALL increment on each sample edge, modulo DATA_WIDTH.
REQ-021 miso_en SHALL be high only while in READ and cs_sync is low.
REQ-022 WRITE: shift in DATA_WIDTH bits MSB-first on sample edges.
REQ-023 WRITE: on the sample edge completing a word, mem[addr] SHALL be written with the full word in the same clk, addr SHALL increment, and bit_cnt SHALL clear.
REQ-024 Burst: READ/WRITE SHALL continue word after word until CS rises.
REQ-025 Address increment SHALL wrap 2**ADDR_WIDTH-1 -> 0.
REQ-026 cs_sync high in any non-IDLE state: -> IDLE next clk, and miso_en low.
REQ-027 A partially received write word SHALL be discarded, with memory unchanged.
REQ-028 If a CS-rise and a word-completing sample edge fall in the same clk, CS SHALL win: no write.
REQ-029 Launch/sample edges SHALL be ignored in IDLE.
REQ-030 Memory SHALL be a register array with combinational read; at most one write per clk.

Reset
REQ-031 While reset is high: state IDLE, bit_cnt 0, addr 0, shift register 0, miso_pin 0, miso_en 0.
REQ-032 While reset is high: cs sync flops = 1, sclk/mosi sync flops = 0, so leds = 4'b0010.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset asserted mid-transaction SHALL abort it immediately (asynchronously).
REQ-035 After reset deasserts, the next CS falling SHALL start a clean command.

Verification (defaults unless stated; sclk half period 8 clk)
REQ-036 Assert reset -> miso_en=0, miso_pin=0, leds=4'b0010 without any clk edge.
REQ-037 Write cmd 0x24 (addr 0x12, W) + 0xA5, CS high; then read cmd 0x25 -> MISO returns 0xA5 MSB-first, miso_en=1 only during the read.
REQ-038 Burst write from 0x7E: 0x11, 0x22, 0x33; burst read from 0x7E -> 0x11, 0x22, 0x33 (third word at 0x00, wrap).
REQ-039 mem[0x10]=0x5A; write cmd to 0x10, CS raised after 5 data bits -> mem[0x10] stays 0x5A; next read of 0x10 returns 0x5A.
REQ-040 Reset pulsed mid-read at data bit 3 -> miso_en=0 and state IDLE immediately; following transaction correct.
REQ-041 CPHA=1, DATA_WIDTH=16, ADDR_WIDTH=4: write 0xBEEF to addr 0xF, then read back -> 0xBEEF.

Source files
------------

// File: rtl/spi_memory_burst.sv
// SPI slave in front of a small register-array memory. A command of address bits
// plus an R/W bit opens a read or write burst that runs word after word until CS rises.
module spi_memory_burst #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CPHA        = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_en,
  output logic [3:0] leds
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CMD   = 2'b01,
    READ  = 2'b10,
    WRITE = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
  state_t                 state_q, state_d;
  logic [CW-1:0]          bitCnt_q, bitCnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  memWdata;
  logic                   memWe;
  logic                   csSync, mosiSync, sclkRise, sclkFall, sampleEdge, launchEdge;

  // Bit 0 of each chain is the newest sample; edges come from the last two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclkSync_q <= '0;
      csSync_q   <= '1;
      mosiSync_q <= '0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_pin};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_pin};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi_pin};
    end
  end

  assign csSync     = csSync_q[SYNC_STAGES-1];
  assign mosiSync   = mosiSync_q[SYNC_STAGES-1];
  assign sclkRise   = sclkSync_q[SYNC_STAGES-2] & ~sclkSync_q[SYNC_STAGES-1];
  assign sclkFall   = ~sclkSync_q[SYNC_STAGES-2] & sclkSync_q[SYNC_STAGES-1];
  assign sampleEdge = (CPHA != 0) ? sclkFall : sclkRise;
  assign launchEdge = (CPHA != 0) ? sclkRise : sclkFall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      addr_q   <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      addr_q   <= addr_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    addr_d   = addr_q;
    shift_d  = shift_q;
    memWe    = 1'b0;
    memWdata = DATA_WIDTH'({shift_q, mosiSync});
    case (state_q)
      IDLE: begin
        if (!csSync) begin
          state_d  = CMD;
          bitCnt_d = '0;
        end
      end
      CMD: begin
        if (csSync) begin
          state_d = IDLE;
        end else if (sampleEdge) begin
          // The address shifts straight into addr_q, so it is complete by the R/W bit.
          if (bitCnt_q == CW'(ADDR_WIDTH)) begin
            state_d  = mosiSync ? READ : WRITE;
            bitCnt_d = '0;
          end else begin
            addr_d   = ADDR_WIDTH'({addr_q, mosiSync});
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      READ: begin
        if (csSync) begin
          state_d = IDLE;
        end else if (launchEdge) begin
          if (bitCnt_q == '0) begin
            shift_d = mem[addr_q];
            addr_d  = addr_q + 1'b1;
          end else begin
            shift_d = shift_q << 1;
          end
        end else if (sampleEdge) begin
          bitCnt_d = (bitCnt_q == CW'(DATA_WIDTH - 1)) ? '0 : bitCnt_q + 1'b1;
        end
      end
      WRITE: begin
        // CS rising takes priority, so a word completing in the same clk is dropped.
        if (csSync) begin
          state_d = IDLE;
        end else if (sampleEdge) begin
          if (bitCnt_q == CW'(DATA_WIDTH - 1)) begin
            memWe    = 1'b1;
            addr_d   = addr_q + 1'b1;
            bitCnt_d = '0;
          end else begin
            shift_d  = memWdata;
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[addr_q] <= memWdata;
    end
  end

  assign miso_pin = shift_q[DATA_WIDTH-1];
  assign miso_en  = (state_q == READ) && !csSync;
  assign leds     = {state_q, csSync, miso_en};

endmodule

// File: tb/tb_spi_memory_burst.sv
// Bench for spi_memory_burst: a default-parameter instance driven as SPI mode 0 and a
// CPHA=1 / 16-bit / 4-bit-address instance driven as mode 1, checked against array models.
module tb_spi_memory_burst;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclkA = 1'b0, csA = 1'b1, mosiA = 1'b0;
  logic       misoA, enA;
  logic [3:0] ledsA;
  logic       sclkB = 1'b0, csB = 1'b1, mosiB = 1'b0;
  logic       misoB, enB;
  logic [3:0] ledsB;

  int passCount = 0;
  int checkCount = 0;

  // Reference memories: plain arrays indexed modulo depth.
  logic [7:0]  modelA [128];
  logic [15:0] modelB [16];
  logic [31:0] words [4];
  logic [31:0] rdata;
  int          enCount;
  int          baseAddr;
  int          burstLen;

  always #5 clk = ~clk;

  spi_memory_burst dutA (
    .clk      (clk),
    .reset    (reset),
    .sclk_pin (sclkA),
    .cs_pin   (csA),
    .mosi_pin (mosiA),
    .miso_pin (misoA),
    .miso_en  (enA),
    .leds     (ledsA)
  );

  spi_memory_burst #(
    .ADDR_WIDTH  (4),
    .DATA_WIDTH  (16),
    .SYNC_STAGES (2),
    .CPHA        (1)
  ) dutB (
    .clk      (clk),
    .reset    (reset),
    .sclk_pin (sclkB),
    .cs_pin   (csB),
    .mosi_pin (mosiB),
    .miso_pin (misoB),
    .miso_en  (enB),
    .leds     (ledsB)
  );

  // Compare one observed value against the bench-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI bit with half period 8 clk; the master captures MISO just before its sample edge.
  task automatic applyStimulus(input bit useB, input logic b, output logic m, output logic en);
    if (!useB) begin
      mosiA = b;
      waitClk(8);
      m = misoA;
      en = enA;
      sclkA = 1'b1;
      waitClk(8);
      sclkA = 1'b0;
    end else begin
      sclkB = 1'b1;
      mosiB = b;
      waitClk(8);
      m = misoB;
      en = enB;
      sclkB = 1'b0;
      waitClk(8);
    end
  endtask

  // Shift n bits MSB-first, collecting MISO and counting bits where miso_en was high.
  task automatic sendBits(input bit useB, input logic [31:0] v, input int n,
                          output logic [31:0] r, output int enCnt);
    logic m, en;
    r = '0;
    enCnt = 0;
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(useB, v[i], m, en);
      r = {r[30:0], m};
      enCnt += int'(en);
    end
  endtask

  task automatic csDown(input bit useB);
    if (useB) csB = 1'b0;
    else csA = 1'b0;
    waitClk(8);
  endtask

  task automatic csUp(input bit useB);
    waitClk(4);
    if (useB) csB = 1'b1;
    else csA = 1'b1;
    waitClk(8);
  endtask

  task automatic startCmd(input bit useB, input int addr, input logic rw, output int enCnt);
    logic [31:0] r;
    int aw;
    aw = useB ? 4 : 7;
    csDown(useB);
    sendBits(useB, (32'(addr) << 1) | 32'(rw), aw + 1, r, enCnt);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset is applied before the first clk edge; outputs must settle asynchronously.
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_misoEnA", 32'(enA), 32'd0);
    checkOutput("rst_misoA", 32'(misoA), 32'd0);
    checkOutput("rst_ledsA", 32'(ledsA), 32'h2);
    checkOutput("rst_misoEnB", 32'(enB), 32'd0);
    checkOutput("rst_ledsB", 32'(ledsB), 32'h2);
    waitClk(3);
    reset = 1'b0;
    waitClk(4);

    // Single write of 0xA5 to 0x12, then single read.
    startCmd(1'b0, 'h12, 1'b0, enCount);
    checkOutput("wrCmd_en", 32'(enCount), 32'd0);
    sendBits(1'b0, 32'hA5, 8, rdata, enCount);
    checkOutput("wrData_en", 32'(enCount), 32'd0);
    csUp(1'b0);
    modelA['h12] = 8'hA5;
    checkOutput("idle_ledsA", 32'(ledsA), 32'h2);
    startCmd(1'b0, 'h12, 1'b1, enCount);
    checkOutput("rdCmd_en", 32'(enCount), 32'd0);
    sendBits(1'b0, 32'h0, 8, rdata, enCount);
    checkOutput("rd12_data", rdata, 32'(modelA['h12]));
    checkOutput("rd12_en", 32'(enCount), 32'd8);
    csUp(1'b0);
    checkOutput("rd12_enAfter", 32'(enA), 32'd0);

    // Burst across the top of the address space.
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    startCmd(1'b0, 'h7E, 1'b0, enCount);
    for (int i = 0; i < 3; i++) begin
      sendBits(1'b0, words[i], 8, rdata, enCount);
      modelA[('h7E + i) % 128] = words[i][7:0];
    end
    csUp(1'b0);
    startCmd(1'b0, 'h7E, 1'b1, enCount);
    for (int i = 0; i < 3; i++) begin
      sendBits(1'b0, 32'h0, 8, rdata, enCount);
      checkOutput($sformatf("wrapRd%0d", i), rdata, 32'(modelA[('h7E + i) % 128]));
    end
    csUp(1'b0);
    checkOutput("wrap_addr0", 32'(modelA[0]), 32'h33);

    // A write aborted after 5 data bits leaves the word untouched.
    startCmd(1'b0, 'h10, 1'b0, enCount);
    sendBits(1'b0, 32'h5A, 8, rdata, enCount);
    csUp(1'b0);
    modelA['h10] = 8'h5A;
    startCmd(1'b0, 'h10, 1'b0, enCount);
    sendBits(1'b0, 32'h15, 5, rdata, enCount);
    csUp(1'b0);
    startCmd(1'b0, 'h10, 1'b1, enCount);
    sendBits(1'b0, 32'h0, 8, rdata, enCount);
    checkOutput("partialWr_keep", rdata, 32'h5A);
    csUp(1'b0);

    // Reset pulsed in the middle of a read, after three data bits.
    startCmd(1'b0, 'h12, 1'b1, enCount);
    sendBits(1'b0, 32'h0, 3, rdata, enCount);
    checkOutput("midRd_bitsEn", 32'(enCount), 32'd3);
    waitClk(2);
    #2 reset = 1'b1;
    #1;
    checkOutput("midRst_en", 32'(enA), 32'd0);
    checkOutput("midRst_leds", 32'(ledsA), 32'h2);
    checkOutput("midRst_miso", 32'(misoA), 32'd0);
    sclkA = 1'b0;
    csA = 1'b1;
    waitClk(3);
    reset = 1'b0;
    waitClk(4);
    startCmd(1'b0, 'h12, 1'b1, enCount);
    sendBits(1'b0, 32'h0, 8, rdata, enCount);
    checkOutput("postRst_rd", rdata, 32'(modelA['h12]));
    csUp(1'b0);

    // Randomised bursts on the default instance.
    for (int it = 0; it < 6; it++) begin
      baseAddr = int'($urandom_range(0, 127));
      burstLen = int'($urandom_range(1, 4));
      startCmd(1'b0, baseAddr, 1'b0, enCount);
      for (int i = 0; i < burstLen; i++) begin
        words[i] = 32'($urandom_range(0, 255));
        sendBits(1'b0, words[i], 8, rdata, enCount);
        modelA[(baseAddr + i) % 128] = words[i][7:0];
      end
      csUp(1'b0);
      startCmd(1'b0, baseAddr, 1'b1, enCount);
      for (int i = 0; i < burstLen; i++) begin
        sendBits(1'b0, 32'h0, 8, rdata, enCount);
        checkOutput($sformatf("rndA%0d_w%0d@%0h", it, i, (baseAddr + i) % 128),
                    rdata, 32'(modelA[(baseAddr + i) % 128]));
      end
      csUp(1'b0);
    end

    // CPHA=1, 16-bit words, 4-bit addresses.
    startCmd(1'b1, 'hF, 1'b0, enCount);
    sendBits(1'b1, 32'hBEEF, 16, rdata, enCount);
    checkOutput("B_wrEn", 32'(enCount), 32'd0);
    csUp(1'b1);
    modelB['hF] = 16'hBEEF;
    startCmd(1'b1, 'hF, 1'b1, enCount);
    sendBits(1'b1, 32'h0, 16, rdata, enCount);
    checkOutput("B_rdF", rdata, 32'(modelB['hF]));
    checkOutput("B_rdEn", 32'(enCount), 32'd16);
    csUp(1'b1);
    checkOutput("B_idleLeds", 32'(ledsB), 32'h2);

    for (int it = 0; it < 3; it++) begin
      baseAddr = int'($urandom_range(12, 15));
      burstLen = int'($urandom_range(2, 4));
      startCmd(1'b1, baseAddr, 1'b0, enCount);
      for (int i = 0; i < burstLen; i++) begin
        words[i] = 32'($urandom_range(0, 65535));
        sendBits(1'b1, words[i], 16, rdata, enCount);
        modelB[(baseAddr + i) % 16] = words[i][15:0];
      end
      csUp(1'b1);
      startCmd(1'b1, baseAddr, 1'b1, enCount);
      for (int i = 0; i < burstLen; i++) begin
        sendBits(1'b1, 32'h0, 16, rdata, enCount);
        checkOutput($sformatf("rndB%0d_w%0d@%0h", it, i, (baseAddr + i) % 16),
                    rdata, 32'(modelB[(baseAddr + i) % 16]));
      end
      csUp(1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
